// File: rtl/rr_sched_pkg.sv
// Shared constants, state encodings and helpers for the round-robin burst scheduler.
// The state encodings are plain localparams so older code that compares raw state bits keeps working.
package rr_sched_pkg;

  localparam int N_REQ  = 4;
  localparam int W_BITS = 4;

  // Quantum used when a weight field is 0: 2**W_BITS beats.
  localparam logic [W_BITS:0] Q_FULL = {1'b1, {W_BITS{1'b0}}};

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] GRANT   = 2'd1;
  localparam logic [1:0] HANDOFF = 2'd2;

  function automatic logic [1:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
    logic [1:0] idx;
    idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (oh[i]) idx = idx | 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: returns the first requester at or after
// ptr, wrapping modulo N_REQ.
module rr_pick
  import rr_sched_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [1:0]       ptr,
  output logic             any,
  output logic [1:0]       idx
);

  logic [1:0] cand;

  // NOTE: every signal written here gets a default before any conditional
  // assignment; a path that leaves one unassigned would infer a latch.
  always_comb begin
    any  = 1'b0;
    idx  = ptr;
    cand = ptr;
    // Scan from the farthest offset down so the closest hit to ptr is written last.
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = ptr + 2'(k);
      if (req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/rr_burst_scheduler.sv
// Weighted round-robin burst scheduler for four requesters sharing one beat port.
// Each grant lasts until the owner drops req or uses its quantum, then one dead cycle follows.
module rr_burst_scheduler
  import rr_sched_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*W_BITS-1:0]   weight,
  input  logic                      beat,
  output logic [N_REQ-1:0]          gnt,
  output logic                      gnt_valid,
  output logic [1:0]                gnt_id,
  output logic                      quantum_exp
);

  logic [1:0]       state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [1:0]       owner_q, owner_d;
  logic [W_BITS:0]  beat_cnt_q, beat_cnt_d;
  logic [W_BITS:0]  quantum_q, quantum_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic             gnt_valid_q, gnt_valid_d;
  logic [1:0]       gnt_id_q, gnt_id_d;
  logic             quantum_exp_q, quantum_exp_d;

  logic             pick_any;
  logic [1:0]       pick_idx;
  logic [W_BITS-1:0] pick_weight;
  logic [W_BITS:0]  cnt_inc;

  rr_pick u_pick (
    .req (req),
    .ptr (ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign pick_weight = weight[pick_idx*W_BITS +: W_BITS];
  assign cnt_inc     = beat_cnt_q + 1'b1;

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    owner_d       = owner_q;
    beat_cnt_d    = beat_cnt_q;
    quantum_d     = quantum_q;
    quantum_exp_d = 1'b0;

    case (state_q)
      GRANT: begin
        if (beat) beat_cnt_d = cnt_inc;
        // Quantum exhaustion wins over a simultaneous request drop.
        if (beat && (cnt_inc == quantum_q)) begin
          state_d       = HANDOFF;
          quantum_exp_d = 1'b1;
        end else if (!req[owner_q]) begin
          state_d = HANDOFF;
        end
      end
      default: begin
        // IDLE and HANDOFF both arbitrate; the quantum is frozen at grant time.
        if (pick_any) begin
          state_d    = GRANT;
          owner_d    = pick_idx;
          ptr_d      = pick_idx + 2'd1;
          beat_cnt_d = '0;
          quantum_d  = (pick_weight == '0) ? Q_FULL : {1'b0, pick_weight};
        end else begin
          state_d = IDLE;
        end
      end
    endcase

    gnt_d       = (state_d == GRANT) ? (4'b0001 << owner_d) : '0;
    gnt_valid_d = |gnt_d;
    gnt_id_d    = onehot_to_idx(gnt_d);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      owner_q       <= '0;
      beat_cnt_q    <= '0;
      quantum_q     <= '0;
      gnt_q         <= '0;
      gnt_valid_q   <= 1'b0;
      gnt_id_q      <= '0;
      quantum_exp_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      owner_q       <= owner_d;
      beat_cnt_q    <= beat_cnt_d;
      quantum_q     <= quantum_d;
      gnt_q         <= gnt_d;
      gnt_valid_q   <= gnt_valid_d;
      gnt_id_q      <= gnt_id_d;
      quantum_exp_q <= quantum_exp_d;
    end
  end

  assign gnt         = gnt_q;
  assign gnt_valid   = gnt_valid_q;
  assign gnt_id      = gnt_id_q;
  assign quantum_exp = quantum_exp_q;

endmodule

// File: tb/tb_rr_burst_scheduler.sv
// Directed bench for rr_burst_scheduler: a table of per-cycle vectors plus
// hand-written sequences for asynchronous reset and the 16-beat zero-weight quantum.
module tb_rr_burst_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [15:0] weight;
  logic        beat;
  logic [3:0]  gnt;
  logic        gnt_valid;
  logic [1:0]  gnt_id;
  logic        quantum_exp;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [3:0]  req;
    logic [15:0] weight;
    logic        beat;
    logic [3:0]  exp_gnt;
    logic        exp_qexp;
  } vec_t;

  vec_t vecs[$];

  rr_burst_scheduler dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .weight      (weight),
    .beat        (beat),
    .gnt         (gnt),
    .gnt_valid   (gnt_valid),
    .gnt_id      (gnt_id),
    .quantum_exp (quantum_exp)
  );

  always #5 clk = ~clk;

  function automatic void add(input logic [3:0] r, input logic [15:0] w, input logic b,
                              input logic [3:0] eg, input logic eq);
    vec_t v;
    v.req = r; v.weight = w; v.beat = b; v.exp_gnt = eg; v.exp_qexp = eq;
    vecs.push_back(v);
  endfunction

  // gnt_valid and gnt_id expectations follow from the expected one-hot gnt.
  task automatic check(input string name, input logic [3:0] eg, input logic eq);
    logic       ev;
    logic [1:0] eid;
    ev  = (eg != 4'b0000);
    eid = 2'd0;
    for (int i = 0; i < 4; i++) if (eg[i]) eid = 2'(i);
    n_vec++;
    if (gnt !== eg || gnt_valid !== ev || gnt_id !== eid || quantum_exp !== eq) begin
      n_err++;
      $display("FAIL %s: got gnt=%b valid=%b id=%0d qexp=%b, want gnt=%b valid=%b id=%0d qexp=%b",
               name, gnt, gnt_valid, gnt_id, quantum_exp, eg, ev, eid, eq);
    end
  endtask

  task automatic step(input logic [3:0] r, input logic [15:0] w, input logic b);
    @(negedge clk);
    req = r; weight = w; beat = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Full load, all quanta 2: owners 0,1,2,3,0, each 2 cycles then a dead cycle.
    for (int g = 0; g < 5; g++) begin
      add(4'hF, 16'h2222, 1'b1, 4'b0001 << (g % 4), 1'b0);
      add(4'hF, 16'h2222, 1'b1, 4'b0001 << (g % 4), 1'b0);
      add(4'hF, 16'h2222, 1'b1, 4'b0000,            1'b1);
    end
    add(4'h0, 16'h2222, 1'b0, 4'b0000, 1'b0);  // requests gone -> IDLE
    add(4'h0, 16'h2222, 1'b1, 4'b0000, 1'b0);  // beat in IDLE ignored
    // Early release: requester 1, weight 5, drop after 2 beats (ptr=1 here).
    add(4'b0010, 16'h0050, 1'b1, 4'b0010, 1'b0);
    add(4'b0010, 16'h0050, 1'b1, 4'b0010, 1'b0);
    add(4'b0010, 16'h0050, 1'b1, 4'b0010, 1'b0);
    add(4'b0000, 16'h0050, 1'b0, 4'b0000, 1'b0);
    add(4'b0000, 16'h0050, 1'b0, 4'b0000, 1'b0);
    // Weight 3 on requester 2; third beat coincides with the request drop.
    add(4'b0100, 16'h0300, 1'b0, 4'b0100, 1'b0);
    add(4'b0100, 16'h0300, 1'b1, 4'b0100, 1'b0);
    add(4'b0100, 16'h0300, 1'b1, 4'b0100, 1'b0);
    add(4'b0000, 16'h0300, 1'b1, 4'b0000, 1'b1);
    add(4'b0000, 16'h0300, 1'b1, 4'b0000, 1'b0);  // beat in HANDOFF ignored
    // Weight changed to 1 mid-grant: the grant keeps its sampled quantum of 3.
    add(4'b0100, 16'h0300, 1'b0, 4'b0100, 1'b0);
    add(4'b0100, 16'h0100, 1'b1, 4'b0100, 1'b0);
    add(4'b0100, 16'h0100, 1'b1, 4'b0100, 1'b0);
    add(4'b0100, 16'h0100, 1'b1, 4'b0000, 1'b1);
    add(4'b0000, 16'h0100, 1'b0, 4'b0000, 1'b0);
    // Pointer wrap with ptr=3 and req=1001: owners 3, 0, 3.
    add(4'b1001, 16'h1001, 1'b0, 4'b1000, 1'b0);
    add(4'b1001, 16'h1001, 1'b1, 4'b0000, 1'b1);
    add(4'b1001, 16'h1001, 1'b0, 4'b0001, 1'b0);
    add(4'b1001, 16'h1001, 1'b1, 4'b0000, 1'b1);
    add(4'b1001, 16'h1001, 1'b0, 4'b1000, 1'b0);

    rst_n = 1'b0; req = '0; weight = '0; beat = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_state", 4'b0000, 1'b0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].req, vecs[i].weight, vecs[i].beat);
      check($sformatf("vec%0d", i), vecs[i].exp_gnt, vecs[i].exp_qexp);
    end

    // Reset mid-burst: owner 3 is in GRANT with ptr 0; outputs must clear without a clock edge.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_clear", 4'b0000, 1'b0);
    req = 4'b1010; weight = 16'h0000; beat = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_release_no_grant_yet", 4'b0000, 1'b0);
    @(posedge clk);
    #1;
    check("first_grant_after_reset", 4'b0010, 1'b0);

    // Return to IDLE (ptr=2), then a 16-beat zero-weight grant on requester 2.
    step(4'b0000, 16'h0000, 1'b0);
    check("reset_seq_release", 4'b0000, 1'b0);
    step(4'b0000, 16'h0000, 1'b0);
    check("reset_seq_idle", 4'b0000, 1'b0);
    step(4'b0100, 16'h0000, 1'b1);
    check("zero_weight_grant", 4'b0100, 1'b0);
    for (int b = 1; b <= 16; b++) begin
      step(4'b0100, 16'h0000, 1'b1);
      if (b < 16) check($sformatf("zero_weight_beat%0d", b), 4'b0100, 1'b0);
      else        check("zero_weight_expire", 4'b0000, 1'b1);
    end
    step(4'b0000, 16'h0000, 1'b0);
    check("zero_weight_pulse_end", 4'b0000, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rr_burst_scheduler.md
# rr_burst_scheduler

Weighted round-robin scheduler that shares one beat-oriented resource port between four requesters. A requester holds the grant for a bounded burst: until it drops its request or uses up its per-requester beat quantum. Between any two grants there is one dead cycle so the resource mux can switch. The block sits in front of the shared resource mux and drives its one-hot select and owner ID.

## Interface
- N_REQ, 4, number of requesters (fixed at 4 in this revision)
- W_BITS, 4, width of each per-requester quantum field

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req  in  N_REQ  request level per requester; bit i = requester i
- weight  in  N_REQ*W_BITS  packed quanta; field i = weight[i*W_BITS +: W_BITS]; value 0 means 2**W_BITS beats
- beat  in  1  resource accepted one beat from the current owner this cycle; ignored while gnt_valid=0
- gnt  out  N_REQ  one-hot grant, registered
- gnt_valid  out  1  asserted when gnt is nonzero
- gnt_id  out  2  binary index of the owner; 0 when gnt_valid=0
- quantum_exp  out  1  one-cycle pulse: the grant was released because the quantum was exhausted

## Operation
- State machine states:
  - IDLE: no grant.
  - GRANT: owner held.
  - HANDOFF: one mandatory dead cycle, gnt=0.
- Arbitration (IDLE and HANDOFF only):
  - Rotating priority: the search starts at ptr and wraps modulo 4.
  - The winner is the first requester i with req[i]=1.
  - If any req is set, go to GRANT with owner=winner, beat_cnt=0, and ptr <= winner+1 (mod 4). Otherwise go to IDLE.
- GRANT transitions:
  - On beat=1, beat_cnt increments.
  - If beat=1 and beat_cnt+1 equals the owner's quantum: go to HANDOFF, quantum_exp=1 for the next cycle.
  - Else if req[owner]=0: go to HANDOFF, quantum_exp=0.
  - Else stay in GRANT.
- Simultaneous quantum hit and request drop: the beat counts and quantum_exp pulses (quantum has priority).
- A beat with req[owner]=0 in the same cycle still counts; the resource owns beat validity.
- Weights are sampled when the grant is issued; changing weight mid-grant has no effect on that grant.
- A sole persistent requester is re-granted after every HANDOFF, so the steady state is quantum beats followed by 1 dead cycle.
- beat_cnt is W_BITS+1 bits wide; the quantum compare is done at W_BITS+1 bits, so weight 0 maps to 16 at the default width.

## Timing
- Reset values: state=IDLE, ptr=0, owner=0, beat_cnt=0, gnt=0, gnt_valid=0, gnt_id=0, quantum_exp=0.
- Request-to-grant latency: req seen in IDLE at cycle t gives gnt at t+1.
- Release-to-next-grant: release decided at t gives gnt=0 at t+1 (HANDOFF) and the new gnt at t+2.
- gnt, gnt_valid, gnt_id and quantum_exp are all registered; there is no combinational path from req or beat to the outputs.
- Reset mid-burst: outputs clear asynchronously and ptr returns to 0. The first grant after reset release goes to the lowest-index active requester.
- gnt is never multi-hot. gnt_valid equals |gnt in every cycle.

## Structure
- Package rr_sched_pkg:
  - state enum {IDLE, GRANT, HANDOFF}
  - N_REQ and W_BITS defaults
  - function onehot_to_idx
- Sub-module rr_pick: combinational rotating-priority picker.
  - Inputs: req[N_REQ-1:0], ptr[1:0].
  - Outputs: any, idx[1:0].
  - Instantiated once. It is reusable by other arbiters in the codebase.
- Top level holds the FSM, ptr, owner, beat_cnt, latched quantum and output registers.

## Test plan
- Fairness under full load: req=4'b1111, all weights=2, beat held at 1 → owners go 0,1,2,3,0. Each grant lasts 2 cycles, followed by 1 dead cycle, with quantum_exp pulsing after each grant.
- Early release: req=4'b0010, weight[1]=5. Drop req[1] after 2 beats → HANDOFF next cycle, quantum_exp=0, then IDLE.
- Zero weight: weight[2]=0, req=4'b0100, beat=1 continuously → grant lasts exactly 16 beats, then quantum_exp=1.
- Simultaneous events: at the 3rd beat of a weight-3 grant, also drop req[owner] → exactly one HANDOFF with quantum_exp=1. Also check that a beat during HANDOFF or IDLE leaves all counts unchanged.
- Reset mid-operation: assert rst_n=0 during GRANT with owner=3 and ptr=0 → all outputs drop to 0 immediately. After release with req=4'b1010, the first gnt is 4'b0010 at one cycle latency.
- Pointer wrap: owner=3 released while req=4'b1001 → next owner is 0, and the owner after that is 3.
